ssfr_readback: RTL and testbench

- Readback path for the NPU configuration and status registers: the reverse direction of the DA/DB byte-pair configuration write into SSFR.
- On a host read request, snapshots one 16-bit word and returns it as three bytes over an 8-bit valid/ready stream: low byte (DA half), high byte (DB half), then a check byte.
- Sits beside the SSFR register on the CLKEXT domain, between the register file and the host interface.

---
 rtl/ssfr_readback.sv | 116 +++++++++++
 tb/tb_ssfr_readback.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ssfr_readback.sv
// ssfr_readback -- host readback of the NPU configuration/status words.
//
// A read request snapshots one 16-bit word and streams it back as three
// bytes over an 8-bit valid/ready interface: low byte, high byte, then a
// check byte (lo ^ hi ^ addr) flagged with DOUT_LAST.
//
// Ports:
//   CLKEXT      system clock, rising edge
//   RST_N       synchronous active-low reset
//   RD_REQ      single-cycle read request (accepted only when idle)
//   RD_ADDR     0=SSFR, 1=STATUS, 2=RESULT, 3=completed-transaction counter
//   SSFR/STATUS/RESULT  live source words
//   DOUT, DOUT_VALID, DOUT_READY, DOUT_LAST  byte stream to the host
//   BUSY        transaction in progress
//   RD_ERR      sticky: a request arrived while busy
module ssfr_readback #(
  parameter logic [15:0] RST_SSFR = 16'h2280,
  parameter int          CNT_W    = 16
) (
  input  logic        CLKEXT,
  input  logic        RST_N,
  input  logic        RD_REQ,
  input  logic [1:0]  RD_ADDR,
  input  logic [15:0] SSFR,
  input  logic [15:0] STATUS,
  input  logic [15:0] RESULT,
  output logic [7:0]  DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        DOUT_LAST,
  output logic        BUSY,
  output logic        RD_ERR
);

  // Snapshot width follows the register word width.
  localparam int SNAP_W = $bits(RST_SSFR);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_CHK} state_t;

  state_t              state, state_nxt;
  logic [SNAP_W-1:0]   snap;
  logic [SNAP_W-1:0]   word_sel;
  logic [1:0]          addr_q;
  logic [CNT_W-1:0]    cnt;
  logic                rd_err_q;
  logic                hs, accept, done;

  // Handshake depends only on registered VALID, so READY never reaches VALID
  // combinationally.
  assign hs     = DOUT_VALID & DOUT_READY;
  assign accept = RD_REQ & (state == IDLE);
  assign done   = (state == SEND_CHK) & hs;

  always_comb begin
    word_sel = '0;
    case (RD_ADDR)
      2'd0: word_sel = SSFR;
      2'd1: word_sel = STATUS;
      2'd2: word_sel = RESULT;
      2'd3: word_sel = cnt;  // pre-increment value of this transaction
      default: word_sel = '0;
    endcase
  end

  // State register
  always_ff @(posedge CLKEXT) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (RD_REQ) state_nxt = SEND_LO;
      SEND_LO:  if (hs)     state_nxt = SEND_HI;
      SEND_HI:  if (hs)     state_nxt = SEND_CHK;
      SEND_CHK: if (hs)     state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Datapath registers: snapshot, address, counter, sticky error.
  always_ff @(posedge CLKEXT) begin
    if (!RST_N) begin
      snap     <= '0;
      addr_q   <= '0;
      cnt      <= '0;
      rd_err_q <= 1'b0;
    end else begin
      if (accept) begin
        snap   <= word_sel;
        addr_q <= RD_ADDR;
      end
      if (done) cnt <= cnt + 1'b1;  // wraps naturally
      // Includes the SEND_CHK completion edge: still busy there.
      if (RD_REQ && state != IDLE) rd_err_q <= 1'b1;
    end
  end

  // Output logic
  always_comb begin
    DOUT       = 8'h00;
    DOUT_VALID = (state != IDLE);
    BUSY       = (state != IDLE);
    DOUT_LAST  = (state == SEND_CHK);
    RD_ERR     = rd_err_q;
    case (state)
      SEND_LO:  DOUT = snap[7:0];
      SEND_HI:  DOUT = snap[15:8];
      SEND_CHK: DOUT = snap[7:0] ^ snap[15:8] ^ {6'b0, addr_q};
      default:  DOUT = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ssfr_readback.sv
module tb_ssfr_readback;
  logic        CLKEXT = 1'b0;
  logic        RST_N;
  logic        RD_REQ;
  logic [1:0]  RD_ADDR;
  logic [15:0] SSFR, STATUS, RESULT;
  logic [7:0]  DOUT;
  logic        DOUT_VALID, DOUT_READY, DOUT_LAST, BUSY, RD_ERR;

  int n_chk = 0;
  int n_fail = 0;

  ssfr_readback dut (
    .CLKEXT(CLKEXT), .RST_N(RST_N), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
    .SSFR(SSFR), .STATUS(STATUS), .RESULT(RESULT),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .DOUT_LAST(DOUT_LAST), .BUSY(BUSY), .RD_ERR(RD_ERR)
  );

  always #5 CLKEXT = ~CLKEXT;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] ssfr, status, result;
    logic [7:0]  lo, hi, chk;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic idle_checks(input string tag);
    check({tag, " valid"}, 16'(DOUT_VALID), 16'd0);
    check({tag, " busy"},  16'(BUSY),       16'd0);
    check({tag, " last"},  16'(DOUT_LAST),  16'd0);
    check({tag, " dout"},  16'(DOUT),       16'h00);
  endtask

  task automatic byte_checks(input string tag, input logic [7:0] b, input logic last);
    check({tag, " valid"}, 16'(DOUT_VALID), 16'd1);
    check({tag, " busy"},  16'(BUSY),       16'd1);
    check({tag, " last"},  16'(DOUT_LAST),  16'(last));
    check({tag, " dout"},  16'(DOUT),       16'(b));
  endtask

  // Full read with DOUT_READY held high: one byte per cycle.
  task automatic do_read(input string tag, input logic [1:0] a,
                         input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] ck);
    @(negedge CLKEXT); RD_REQ = 1'b1; RD_ADDR = a; DOUT_READY = 1'b1;
    @(negedge CLKEXT); RD_REQ = 1'b0; byte_checks({tag, " lo"}, lo, 1'b0);
    @(negedge CLKEXT); byte_checks({tag, " hi"}, hi, 1'b0);
    @(negedge CLKEXT); byte_checks({tag, " chk"}, ck, 1'b1);
    @(negedge CLKEXT); idle_checks({tag, " end"});
  endtask

  vec_t vt[6];

  initial begin
    // Counter runs 0..5 across these reads.
    vt[0] = '{2'd0, 16'h2280, 16'h0000, 16'h0000, 8'h80, 8'h22, 8'hA2};
    vt[1] = '{2'd1, 16'h2280, 16'h1234, 16'h0000, 8'h34, 8'h12, 8'h27};
    vt[2] = '{2'd2, 16'h2280, 16'h1234, 16'h0007, 8'h07, 8'h00, 8'h05};
    vt[3] = '{2'd3, 16'h2280, 16'h1234, 16'h0007, 8'h03, 8'h00, 8'h00};
    vt[4] = '{2'd3, 16'h2280, 16'h1234, 16'h0007, 8'h04, 8'h00, 8'h07};
    vt[5] = '{2'd2, 16'h2280, 16'h1234, 16'hA55A, 8'h5A, 8'hA5, 8'hFD};

    RST_N = 1'b0; RD_REQ = 1'b0; RD_ADDR = 2'd0; DOUT_READY = 1'b0;
    SSFR = 16'h2280; STATUS = 16'h0000; RESULT = 16'h0000;
    repeat (2) @(negedge CLKEXT);
    idle_checks("reset");
    check("reset rd_err", 16'(RD_ERR), 16'd0);
    RST_N = 1'b1;

    foreach (vt[i]) begin
      SSFR = vt[i].ssfr; STATUS = vt[i].status; RESULT = vt[i].result;
      do_read($sformatf("vec%0d", i), vt[i].addr, vt[i].lo, vt[i].hi, vt[i].chk);
    end
    check("no err after clean reads", 16'(RD_ERR), 16'd0);

    // Ready toggling plus snapshot isolation (counter 6 -> 7).
    RESULT = 16'h0007;
    @(negedge CLKEXT); RD_REQ = 1'b1; RD_ADDR = 2'd2; DOUT_READY = 1'b0;
    @(negedge CLKEXT); RD_REQ = 1'b0; RESULT = 16'hFFFF;
    byte_checks("tog lo0", 8'h07, 1'b0);
    @(negedge CLKEXT); byte_checks("tog lo1", 8'h07, 1'b0); DOUT_READY = 1'b1;
    @(negedge CLKEXT); byte_checks("tog hi0", 8'h00, 1'b0); DOUT_READY = 1'b0;
    @(negedge CLKEXT); byte_checks("tog hi1", 8'h00, 1'b0); DOUT_READY = 1'b1;
    @(negedge CLKEXT); byte_checks("tog chk0", 8'h05, 1'b1); DOUT_READY = 1'b0;
    @(negedge CLKEXT); byte_checks("tog chk1", 8'h05, 1'b1); DOUT_READY = 1'b1;
    @(negedge CLKEXT); idle_checks("tog end");

    // Request during SEND_HI is ignored and flags RD_ERR (counter 7 -> 8).
    SSFR = 16'h2280;
    @(negedge CLKEXT); RD_REQ = 1'b1; RD_ADDR = 2'd0; DOUT_READY = 1'b1;
    @(negedge CLKEXT); RD_REQ = 1'b0; byte_checks("err lo", 8'h80, 1'b0);
    @(negedge CLKEXT); byte_checks("err hi", 8'h22, 1'b0);
    RD_REQ = 1'b1; RD_ADDR = 2'd1; SSFR = 16'hDEAD;
    @(negedge CLKEXT); RD_REQ = 1'b0; byte_checks("err chk", 8'hA2, 1'b1);
    check("err set", 16'(RD_ERR), 16'd1);
    @(negedge CLKEXT); idle_checks("err end");
    do_read("cnt8", 2'd3, 8'h08, 8'h00, 8'h0B);
    check("err sticky", 16'(RD_ERR), 16'd1);

    // Reset in the middle of a word abandons it and clears everything.
    SSFR = 16'h2280; STATUS = 16'h1234;
    @(negedge CLKEXT); RD_REQ = 1'b1; RD_ADDR = 2'd0; DOUT_READY = 1'b1;
    @(negedge CLKEXT); RD_REQ = 1'b0; byte_checks("rst lo", 8'h80, 1'b0);
    @(negedge CLKEXT); byte_checks("rst hi", 8'h22, 1'b0); RST_N = 1'b0;
    @(negedge CLKEXT); idle_checks("rst mid");
    check("rst rd_err", 16'(RD_ERR), 16'd0);
    RST_N = 1'b1;
    do_read("rst cnt", 2'd3, 8'h00, 8'h00, 8'h03);
    do_read("rst status", 2'd1, 8'h34, 8'h12, 8'h27);

    // Counter wrap: preload the state 65535 completed reads would leave,
    // instead of spending ~262k cycles getting there.
    @(negedge CLKEXT); force dut.cnt = 16'hFFFF;
    @(negedge CLKEXT); release dut.cnt;
    do_read("wrap ffff", 2'd3, 8'hFF, 8'hFF, 8'h03);
    do_read("wrap zero", 2'd3, 8'h00, 8'h00, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
